acq_ram_writer: RTL and testbench

//  Downstream of DiscReader: buffers its DATA/WRITE byte strobes in a small FIFO and performs

---
 rtl/acq_ram_writer_pkg.sv | 21 ++
 rtl/acq_sync_fifo.sv | 53 +++++
 rtl/acq_ram_writer.sv | 138 +++++++++++++
 tb/tb_acq_ram_writer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acq_ram_writer_pkg.sv
// Shared definitions for the acquisition SRAM writer:
// FSM state encodings, SRAM active levels and the default address width.
package acq_ram_writer_pkg;

  localparam int ADDR_WIDTH_DEF = 19;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic WE_ON  = 1'b0;
  localparam logic WE_OFF = 1'b1;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/acq_sync_fifo.sv
// Small synchronous byte FIFO with flush; head is read from the
// registered storage at the read pointer.
module acq_sync_fifo
  import acq_ram_writer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same clock frees a slot, so a full FIFO still accepts.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst)
      mem[wr_ptr[AW-1:0]] <= din;
  end

  assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/acq_ram_writer.sv
// Buffers DiscReader byte strobes and paces them into SRAM at an
// auto-incrementing address. Optional ACQ_WRITER_DROP_COUNT_EN adds DROP_COUNT.
module acq_ram_writer
  import acq_ram_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int WE_CYCLES  = 2
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  RUN,
  input  logic                  ADDR_CLR,
  input  logic [7:0]            DATA_IN,
  input  logic                  WRITE_IN,
  output logic [ADDR_WIDTH-1:0] SRAM_ADDR,
  output logic [7:0]            SRAM_DQ_OUT,
  output logic                  SRAM_DQ_OE,
  output logic                  SRAM_WE_N,
  output logic                  MEM_FULL,
  output logic                  OVERRUN,
  output logic                  IDLE
`ifdef ACQ_WRITER_DROP_COUNT_EN
  ,
  output logic [15:0]           DROP_COUNT
`endif
);

  localparam int CW = $clog2(WE_CYCLES) + 1;

  logic [1:0]    state;
  logic [CW-1:0] we_cnt;
  logic [7:0]    head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          clr;
  logic          push_ok;
  logic          last;
  logic          pop;
  logic          drop;
  logic          flush;

  assign clr     = RESET | ADDR_CLR;
  assign push_ok = WRITE_IN & RUN & ~MEM_FULL & ~clr;
  assign last    = (state == S_HOLD) && (SRAM_ADDR == '1);
  assign pop     = ~clr & ~fifo_empty &
                   ((state == S_IDLE) | ((state == S_HOLD) & ~last));
  assign drop    = push_ok & fifo_full & ~pop;
  // Completing the top address discards whatever is still queued.
  assign flush   = ADDR_CLR | last;

  acq_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLOCK),
    .rst   (RESET),
    .push  (push_ok),
    .pop   (pop),
    .flush (flush),
    .din   (DATA_IN),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state       <= S_IDLE;
      we_cnt      <= '0;
      SRAM_ADDR   <= '0;
      SRAM_DQ_OUT <= '0;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_WE_N   <= WE_OFF;
      MEM_FULL    <= 1'b0;
      OVERRUN     <= 1'b0;
    end else if (ADDR_CLR) begin
      state      <= S_IDLE;
      we_cnt     <= '0;
      SRAM_ADDR  <= '0;
      SRAM_DQ_OE <= 1'b0;
      SRAM_WE_N  <= WE_OFF;
      MEM_FULL   <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      if (drop) OVERRUN <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            SRAM_DQ_OUT <= head;
            SRAM_DQ_OE  <= 1'b1;
            state       <= S_SETUP;
          end
        end
        S_SETUP: begin
          SRAM_WE_N <= WE_ON;
          we_cnt    <= CW'(WE_CYCLES - 1);
          state     <= S_STROBE;
        end
        S_STROBE: begin
          if (we_cnt == '0) begin
            SRAM_WE_N <= WE_OFF;
            state     <= S_HOLD;
          end else begin
            we_cnt <= we_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (last) begin
            MEM_FULL   <= 1'b1;
            SRAM_DQ_OE <= 1'b0;
            state      <= S_IDLE;
          end else begin
            SRAM_ADDR <= SRAM_ADDR + 1'b1;
            if (pop) begin
              SRAM_DQ_OUT <= head;
              state       <= S_SETUP;
            end else begin
              SRAM_DQ_OE <= 1'b0;
              state      <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign IDLE = fifo_empty && (state == S_IDLE);

`ifdef ACQ_WRITER_DROP_COUNT_EN
  always_ff @(posedge CLOCK) begin
    if (clr)       DROP_COUNT <= '0;
    else if (drop) DROP_COUNT <= sat_inc16(DROP_COUNT);
  end
`endif

endmodule

// File: tb/tb_acq_ram_writer.sv
// Randomized self-checking bench for acq_ram_writer with a
// behavioural SRAM that latches data on the WE_N rising edge.
module tb_acq_ram_writer;

  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam int WEC   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b1;
  logic          addr_clr = 1'b0;
  logic [7:0]    data_in = '0;
  logic          write_in = 1'b0;
  logic [AW-1:0] sram_addr;
  logic [7:0]    sram_dq;
  logic          sram_oe;
  logic          sram_we_n;
  logic          mem_full;
  logic          overrun;
  logic          idle;
`ifdef ACQ_WRITER_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0]    sram [16];
  int            wcount = 0;
  bit            mon_en = 1'b1;
  logic          prev_we_n = 1'b1;
  int            low_cnt = 0;
  logic [AW-1:0] fall_addr;
  logic [7:0]    fall_dq;
  logic [7:0]    q[$];

  always #5 clk = ~clk;

  acq_ram_writer #(
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH),
    .WE_CYCLES  (WEC)
  ) dut (
    .CLOCK       (clk),
    .RESET       (rst),
    .RUN         (run),
    .ADDR_CLR    (addr_clr),
    .DATA_IN     (data_in),
    .WRITE_IN    (write_in),
    .SRAM_ADDR   (sram_addr),
    .SRAM_DQ_OUT (sram_dq),
    .SRAM_DQ_OE  (sram_oe),
    .SRAM_WE_N   (sram_we_n),
    .MEM_FULL    (mem_full),
    .OVERRUN     (overrun),
    .IDLE        (idle)
`ifdef ACQ_WRITER_DROP_COUNT_EN
    ,
    .DROP_COUNT  (drop_count)
`endif
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (!sram_we_n) begin
        if (prev_we_n) begin
          fall_addr = sram_addr;
          fall_dq   = sram_dq;
          low_cnt   = 1;
        end else begin
          low_cnt++;
          check("addr_stable", sram_addr, fall_addr);
          check("dq_stable", sram_dq, fall_dq);
        end
        check("oe_in_strobe", sram_oe, 1);
      end else if (!prev_we_n) begin
        check("we_width", low_cnt, WEC);
        check("hold_addr", sram_addr, fall_addr);
        check("hold_dq", sram_dq, fall_dq);
        sram[sram_addr] = sram_dq;
        wcount++;
      end
      prev_we_n = sram_we_n;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    addr_clr = 1'b1;
    tick();
    addr_clr = 1'b0;
    wcount   = 0;
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (idle) break;
    end
    if (i >= 400) check("drain_timeout", 0, 1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    write_in = 1'b1;
    data_in  = b;
    tick();
    write_in = 1'b0;
  endtask

  initial begin
    int n;
    int acc;
    int gap;
    bit mono;

    // reset
    repeat (10) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_we_n", sram_we_n, 1);
    check("rst_oe", sram_oe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq", sram_dq, 0);
    check("rst_idle", idle, 1);
    check("rst_full", mem_full, 0);
    check("rst_ovr", overrun, 0);

    // single byte, latency and strobe
    tick();
    push_byte(8'hA5);
    @(negedge clk);
    check("lat_n_we", sram_we_n, 1);
    tick();
    @(negedge clk);
    check("lat_setup_we", sram_we_n, 1);
    check("lat_setup_oe", sram_oe, 1);
    check("lat_setup_dq", sram_dq, 8'hA5);
    tick();
    @(negedge clk);
    check("lat_strobe_we", sram_we_n, 0);
    check("lat_strobe_addr", sram_addr, 0);
    drain();
    check("one_mem0", sram[0], 8'hA5);
    check("one_wcount", wcount, 1);
    check("one_addr", sram_addr, 1);
    check("one_idle", idle, 1);
    check("one_oe", sram_oe, 0);

    // fill to capacity, then one extra
    tick();
    do_clr();
    for (int k = 0; k < 17; k++) begin
      push_byte(8'(k));
      repeat (5) tick();
    end
    drain();
    for (int k = 0; k < 16; k++)
      check($sformatf("fill_mem%0d", k), sram[k], k);
    check("fill_wcount", wcount, 16);
    check("fill_full", mem_full, 1);
    check("fill_addr", sram_addr, 15);
    check("fill_ovr", overrun, 0);
    tick();
    do_clr();
    @(negedge clk);
    check("clr_full", mem_full, 0);
    check("clr_addr", sram_addr, 0);
    tick();
    push_byte(8'h55);
    drain();
    check("clr_mem0", sram[0], 8'h55);
    check("clr_full2", mem_full, 0);
    check("clr_addr2", sram_addr, 1);

    // back-to-back burst overruns the FIFO
    tick();
    do_clr();
    for (int k = 1; k <= 12; k++) begin
      write_in = 1'b1;
      data_in  = 8'(k);
      tick();
    end
    write_in = 1'b0;
    drain();
    n = 12 - 2;
    acc = DEPTH + n / (2 + WEC) + 1;
    if (acc > 12) acc = 12;
    check("burst_ovr", overrun, 1);
    check("burst_stored", wcount, acc);
    check("burst_first", sram[0], 1);
    mono = 1'b1;
    for (int k = 1; k < wcount && k < 16; k++)
      if (sram[k] <= sram[k-1] || sram[k] > 12) mono = 1'b0;
    check("burst_order", mono, 1);
`ifdef ACQ_WRITER_DROP_COUNT_EN
    check("burst_drops", drop_count, 12 - wcount);
`endif

    // RUN falls two clocks into a burst
    tick();
    do_clr();
    for (int k = 0; k < 6; k++) begin
      if (k == 2) run = 1'b0;
      write_in = 1'b1;
      data_in  = 8'(8'h21 + k);
      tick();
    end
    write_in = 1'b0;
    drain();
    check("run_wcount", wcount, 2);
    check("run_mem0", sram[0], 8'h21);
    check("run_mem1", sram[1], 8'h22);
    check("run_addr", sram_addr, 2);
    check("run_idle", idle, 1);
    run = 1'b1;

    // randomized paced traffic against a queue model
    for (int r = 0; r < 8; r++) begin
      tick();
      do_clr();
      q.delete();
      for (int k = 0; k < 15; k++) begin
        run = ($urandom_range(0, 4) != 0);
        data_in = 8'($urandom);
        if (run) q.push_back(data_in);
        write_in = 1'b1;
        tick();
        write_in = 1'b0;
        run = 1'b1;
        gap = $urandom_range(2 + WEC, 12);
        repeat (gap - 1) tick();
      end
      drain();
      check("rnd_wcount", wcount, q.size());
      for (int k = 0; k < q.size(); k++)
        check($sformatf("rnd%0d_mem%0d", r, k), sram[k], q[k]);
      check("rnd_addr", sram_addr, q.size());
      check("rnd_ovr", overrun, 0);
      check("rnd_full", mem_full, 0);
    end

    // reset in the middle of a strobe
    tick();
    push_byte(8'h77);
    tick();
    tick();
    mon_en = 1'b0;
    @(negedge clk);
    check("mid_strobe", sram_we_n, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_we_n", sram_we_n, 1);
    check("mid_rst_oe", sram_oe, 0);
    check("mid_rst_addr", sram_addr, 0);
    check("mid_rst_dq", sram_dq, 0);
    check("mid_rst_idle", idle, 1);
    prev_we_n = 1'b1;
    mon_en = 1'b1;

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
